clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 166 ++++++++++++++++
 tb/tb_clk_period_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : clk_period_meter
//  Description : Measures period and high time of an asynchronous divided
//                clock in clk cycles, with lock and sticky overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_period_meter #(
    parameter int CNT_W      = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             meas_in,
    input  logic             enable,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             overflow
);

    localparam int               c_MW   = $clog2(LOCK_COUNT + 1);
    localparam logic [c_MW-1:0]  c_LOCK = c_MW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] c_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_EDGE = 2'd1,
        S_MEASURE   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_hi_cap, w_hi_cap_nxt;
    logic [c_MW-1:0]  r_match, w_match_nxt;
    logic             r_first, w_first_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic [CNT_W-1:0] r_high, w_high_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_locked;
    logic             r_overflow, w_overflow_nxt;

    logic             w_rise, w_fall;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [c_MW-1:0]  w_match_inc;

    assign w_rise      = r_s2 & ~r_s3;
    assign w_fall      = ~r_s2 & r_s3;
    assign w_cnt_inc   = (r_cnt == c_MAX) ? c_MAX : r_cnt + CNT_W'(1);
    assign w_match_inc = (r_match == c_LOCK) ? c_LOCK : r_match + c_MW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_cnt      <= '0;
            r_hi_cap   <= '0;
            r_match    <= '0;
            r_first    <= 1'b0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_s1       <= meas_in;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi_cap   <= w_hi_cap_nxt;
            r_match    <= w_match_nxt;
            r_first    <= w_first_nxt;
            r_period   <= w_period_nxt;
            r_high     <= w_high_nxt;
            r_valid    <= w_valid_nxt;
            r_locked   <= (w_match_nxt == c_LOCK);
            r_overflow <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hi_cap_nxt   = r_hi_cap;
        w_match_nxt    = r_match;
        w_first_nxt    = r_first;
        w_period_nxt   = r_period;
        w_high_nxt     = r_high;
        w_valid_nxt    = 1'b0;
        w_overflow_nxt = r_overflow;

        if (clr) begin
            // Results wiped, state kept; the count restarts from zero.
            w_cnt_nxt      = '0;
            w_hi_cap_nxt   = '0;
            w_match_nxt    = '0;
            w_period_nxt   = '0;
            w_high_nxt     = '0;
            w_overflow_nxt = 1'b0;
        end else if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_match_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT_EDGE;
                    w_cnt_nxt   = '0;
                    w_match_nxt = '0;
                end
                S_WAIT_EDGE: begin
                    if (w_rise) begin
                        w_cnt_nxt   = '0;
                        w_first_nxt = 1'b1;
                        w_state_nxt = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (w_rise) begin
                        w_period_nxt = w_cnt_inc;
                        w_high_nxt   = r_hi_cap;
                        w_valid_nxt  = 1'b1;
                        w_cnt_nxt    = '0;
                        w_first_nxt  = 1'b0;
                        if (r_cnt == c_MAX) begin
                            w_overflow_nxt = 1'b1;
                            w_match_nxt    = '0;
                        end else if (!r_first && (w_cnt_inc == r_period)) begin
                            w_match_nxt = w_match_inc;
                        end else begin
                            w_match_nxt = '0;
                        end
                    end else if (r_cnt == c_MAX) begin
                        // Period too long to represent: abandon and resync.
                        w_overflow_nxt = 1'b1;
                        w_match_nxt    = '0;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = S_WAIT_EDGE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (w_fall) begin
                            w_hi_cap_nxt = w_cnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign period     = r_period;
    assign high_time  = r_high;
    assign meas_valid = r_valid;
    assign locked     = r_locked;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_period_meter
//  Description : Directed self-checking bench for clk_period_meter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        meas_in, enable;
    logic [15:0] period, high_time;
    logic        meas_valid, locked, overflow;
    logic        m4, en4;
    logic [3:0]  period4, high4;
    logic        valid4, locked4, ovf4;

    int n_total = 0;
    int n_bad   = 0;
    int div_n   = 0;
    int hi_n    = 0;
    int rises   = 0;
    int v4_cnt  = 0;

    clk_period_meter #(.CNT_W(16), .LOCK_COUNT(4)) dut (
        .clk(clk), .reset(reset), .meas_in(meas_in), .enable(enable), .clr(clr),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .locked(locked), .overflow(overflow)
    );

    clk_period_meter #(.CNT_W(4), .LOCK_COUNT(4)) dut4 (
        .clk(clk), .reset(reset), .meas_in(m4), .enable(en4), .clr(clr),
        .period(period4), .high_time(high4), .meas_valid(valid4),
        .locked(locked4), .overflow(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divided-clock source; a new ratio takes effect at the next period boundary.
    initial begin
        int ph, cur_div, cur_hi;
        logic nv;
        meas_in = 1'b0; ph = 0; cur_div = 0; cur_hi = 0;
        forever begin
            @(negedge clk);
            if (ph == 0) begin
                cur_div = div_n;
                cur_hi  = hi_n;
            end
            if (cur_div == 0) begin
                meas_in = 1'b0;
            end else begin
                nv = (ph < cur_hi);
                if (nv && !meas_in) rises++;
                meas_in = nv;
                ph = (ph + 1 == cur_div) ? 0 : ph + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (valid4) v4_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int maxc, output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < maxc) begin
            @(posedge clk); #1;
            cyc++;
            if (meas_valid) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok, found;
        int cyc, lat, r0, vcount;
        logic lk;

        reset = 1'b0; clr = 1'b0; enable = 1'b0; en4 = 1'b0; m4 = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_val("rst_period", 32'(period), 0);
        check_val("rst_high", 32'(high_time), 0);
        check_val("rst_valid", 32'(meas_valid), 0);
        check_val("rst_locked", 32'(locked), 0);
        check_val("rst_ovf", 32'(overflow), 0);
        @(negedge clk); reset = 1'b1;

        // Narrow counter: saturation with meas_in stuck low.
        en4 = 1'b1; repeat (3) @(negedge clk);
        m4 = 1'b1; repeat (3) @(negedge clk); m4 = 1'b0;
        repeat (15) @(posedge clk); #1;
        check_val("ovf4_early", 32'(ovf4), 0);
        @(posedge clk); #1;
        check_val("ovf4_set", 32'(ovf4), 1);
        check_val("ovf4_no_valid", 32'(v4_cnt), 0);
        check_val("ovf4_locked", 32'(locked4), 0);
        // Back in WAIT_EDGE: first rise only arms, second one measures.
        @(negedge clk); m4 = 1'b1;
        repeat (3) @(negedge clk); m4 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("ovf4_rearm_no_valid", 32'(v4_cnt), 0);
        m4 = 1'b1;
        repeat (3) @(negedge clk); m4 = 1'b0;
        check_val("p4_valid", 32'(v4_cnt), 1);
        check_val("p4_period", 32'(period4), 6);
        check_val("p4_high", 32'(high4), 3);
        check_val("p4_ovf_sticky", 32'(ovf4), 1);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check_val("clr4_ovf", 32'(ovf4), 0);
        check_val("clr4_period", 32'(period4), 0);
        // Rise lands exactly when the counter reaches 15.
        repeat (13) @(negedge clk);
        m4 = 1'b1;
        repeat (3) @(negedge clk); m4 = 1'b0;
        check_val("sat_valid", 32'(v4_cnt), 2);
        check_val("sat_period", 32'(period4), 15);
        check_val("sat_ovf", 32'(ovf4), 1);

        // Divide-by-5 until lock.
        @(negedge clk); enable = 1'b1; div_n = 5; hi_n = 3;
        for (int k = 1; k <= 6; k++) begin
            wait_valid(40, ok, cyc);
            check_val("d5_valid", 32'(ok), 1);
            check_val("d5_period", 32'(period), 5);
            check_val("d5_high", 32'(high_time), 3);
            check_val("d5_locked", 32'(locked), (k >= 5) ? 1 : 0);
            if (k >= 2) check_val("d5_gap", 32'(cyc), 5);
        end

        // Latency from meas_in rise to meas_valid.
        @(posedge meas_in);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            lat++;
            if (meas_valid) break;
        end
        check_val("latency", 32'(lat), 3);

        // Switch to divide-by-3.
        div_n = 3; hi_n = 2;
        found = 1'b0; lk = 1'b1;
        for (int j = 0; j < 3 && !found; j++) begin
            wait_valid(40, ok, cyc);
            check_val("d3_valid", 32'(ok), 1);
            if (period == 16'd3) begin
                found = 1'b1;
                lk = locked;
            end
        end
        check_val("d3_found", 32'(found), 1);
        check_val("d3_unlock", 32'(lk), 0);
        check_val("d3_high", 32'(high_time), 2);
        for (int j = 0; j < 4; j++) wait_valid(40, ok, cyc);
        check_val("d3_relock", 32'(locked), 1);

        // clr coincident with a detected rising edge.
        @(posedge meas_in);
        @(posedge clk); @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check_val("clr_valid", 32'(meas_valid), 0);
        check_val("clr_period", 32'(period), 0);
        check_val("clr_ovf", 32'(overflow), 0);
        check_val("clr_locked", 32'(locked), 0);
        wait_valid(40, ok, cyc);
        check_val("post_clr_period", 32'(period), 3);
        check_val("post_clr_locked", 32'(locked), 0);

        // Enable dropped for 10 cycles.
        wait_valid(40, ok, cyc);
        @(negedge clk); enable = 1'b0;
        vcount = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (meas_valid) vcount++;
        end
        check_val("dis_no_valid", 32'(vcount), 0);
        check_val("dis_period_hold", 32'(period), 3);
        check_val("dis_locked", 32'(locked), 0);
        @(negedge meas_in); enable = 1'b1; r0 = rises;
        wait_valid(40, ok, cyc);
        check_val("en_valid", 32'(ok), 1);
        check_val("en_two_rises", 32'(rises - r0), 2);
        check_val("en_locked", 32'(locked), 0);

        // Reset mid-period.
        wait_valid(40, ok, cyc);
        @(posedge clk); #2;
        reset = 1'b0; #1;
        check_val("mid_rst_period", 32'(period), 0);
        check_val("mid_rst_high", 32'(high_time), 0);
        check_val("mid_rst_locked", 32'(locked), 0);
        check_val("mid_rst_valid", 32'(meas_valid), 0);
        @(negedge meas_in); reset = 1'b1; r0 = rises;
        wait_valid(40, ok, cyc);
        check_val("rst_rel_valid", 32'(ok), 1);
        check_val("rst_rel_two_rises", 32'(rises - r0), 2);
        check_val("rst_rel_period", 32'(period), 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
